// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register plus byte-serial Y86-64 instruction fetch.
// Reads instruction bytes one at a time over a req/ack handshake, decodes
// icode/ifun/rA/rB/valC/valP, presents them with instr_valid, and then waits for
// the PC-update stage to return the next PC on pc_load/newPC.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/addr         byte read request and address (held until ack)
//   imem_rdata/ack        read data, sampled in the ack cycle
//   instr_valid           decoded fields valid (DONE state)
//   PC                    address of the presented instruction
//   icode/ifun/rA/rB      decoded instruction fields
//   valC, valP            constant word and fall-through PC
//   stat                  0 AOK, 1 HLT, 2 ADR, 3 INS
//   pc_load, newPC        consume the instruction and load the next PC
module pc_fetch #(
  parameter logic [63:0] START_PC = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'd1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [63:0] PC,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [1:0]  stat,
  input  logic        pc_load,
  input  logic [63:0] newPC
);

  localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;

  typedef enum logic [1:0] {FETCH, DONE, HALTED} state_t;
  state_t     state;
  logic [3:0] idx;

  function automatic logic [3:0] ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: ilen = 4'd2;
      4'h3, 4'h4, 4'h5:       ilen = 4'd10;
      4'h7, 4'h8:             ilen = 4'd9;
      default:                ilen = 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    has_regs = (ilen(ic) == 4'd2) || (ilen(ic) == 4'd10);
  endfunction

  function automatic logic [1:0] end_stat(input logic [3:0] ic);
    if (ic == 4'h0)      end_stat = HLT;
    else if (ic > 4'hB)  end_stat = INS;
    else                 end_stat = AOK;
  endfunction

  // During byte 0 the opcode is still on the bus, not yet in icode.
  logic [3:0]  cur_icode, cur_len, c_base, c_k;
  logic        last_byte, is_reg, is_c;
  logic [63:0] addr_nxt;

  always_comb begin
    cur_icode = (idx == 4'd0) ? imem_rdata[7:4] : icode;
    cur_len   = ilen(cur_icode);
    last_byte = (idx + 4'd1) == cur_len;
    c_base    = has_regs(cur_icode) ? 4'd2 : 4'd1;
    c_k       = idx - c_base;
    is_reg    = has_regs(cur_icode) && (idx == 4'd1);
    is_c      = (cur_len >= 4'd9) && (idx >= c_base);
    addr_nxt  = imem_addr + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      PC          <= START_PC;
      idx         <= 4'd0;
      imem_req    <= 1'b0;
      imem_addr   <= START_PC;
      instr_valid <= 1'b0;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= 64'd0;
      stat        <= AOK;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // Only reached right after reset or after a pc_load to an
            // out-of-range PC: issue byte 0 or flag the address error.
            if (PC >= MEM_SIZE) begin
              stat        <= ADR;
              state       <= DONE;
              instr_valid <= 1'b1;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= PC;
            end
          end else if (imem_ack) begin
            if (idx == 4'd0) begin
              icode <= imem_rdata[7:4];
              ifun  <= imem_rdata[3:0];
              valP  <= PC + {60'd0, ilen(imem_rdata[7:4])};
            end
            if (is_reg) begin
              rA <= imem_rdata[7:4];
              rB <= imem_rdata[3:0];
            end
            if (is_c) valC[8*c_k[2:0] +: 8] <= imem_rdata;
            idx <= idx + 4'd1;
            if (last_byte) begin
              imem_req    <= 1'b0;
              state       <= DONE;
              instr_valid <= 1'b1;
              stat        <= end_stat(cur_icode);
            end else if (addr_nxt >= MEM_SIZE) begin
              imem_req    <= 1'b0;
              state       <= DONE;
              instr_valid <= 1'b1;
              stat        <= ADR;
            end else begin
              imem_addr <= addr_nxt;
            end
          end
        end
        DONE: begin
          if (pc_load) begin
            instr_valid <= 1'b0;
            if (stat == AOK) begin
              state     <= FETCH;
              PC        <= newPC;
              idx       <= 4'd0;
              icode     <= 4'h0;
              ifun      <= 4'h0;
              rA        <= 4'hF;
              rB        <= 4'hF;
              valC      <= 64'd0;
              valP      <= 64'd0;
              // Request newPC immediately; an out-of-range target is left
              // to the FETCH start path to flag.
              imem_req  <= (newPC < MEM_SIZE);
              imem_addr <= newPC;
            end else begin
              state <= HALTED;
            end
          end
        end
        default: ;  // HALTED is sticky until reset
      endcase
    end
  end

endmodule
